// File: rtl/apb_mem_arbiter.sv
// Round-robin APB master that lets NREQ requesters share one APB memory slave.
// It runs the SETUP/ACCESS sequence, handles wait states and timeouts, and sends the response back to the granted requester.
module apb_mem_arbiter #(
  parameter int NREQ    = 2,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                       PCLK,
  input  logic                       PRESET,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ-1:0]            req_write,
  input  logic [NREQ*ADDR_W-1:0]     req_addr,
  input  logic [NREQ*DATA_W-1:0]     req_wdata,
  output logic [NREQ-1:0]            req_ready,
  output logic                       rsp_valid,
  output logic [$clog2(NREQ)-1:0]    rsp_id,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       rsp_err,
  output logic                       rsp_tmo,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  output logic [ADDR_W-1:0]          PADDR,
  output logic [DATA_W-1:0]          PWDATA,
  input  logic [DATA_W-1:0]          PRDATA,
  input  logic                       PREADY,
  input  logic                       PSLVERR
);
  localparam int ID_W  = $clog2(NREQ);
  localparam int SUM_W = ID_W + 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t              state_reg, state_next;
  logic [ID_W-1:0]     ptr_reg, ptr_next, gnt_reg, gnt_next, pick;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [NREQ-1:0]     ready_reg, ready_next;
  logic                rsp_valid_reg, rsp_valid_next;
  logic [ID_W-1:0]     rsp_id_reg, rsp_id_next;
  logic [DATA_W-1:0]   rsp_rdata_reg, rsp_rdata_next;
  logic                rsp_err_reg, rsp_err_next, rsp_tmo_reg, rsp_tmo_next;
  logic                psel_reg, psel_next, penable_reg, penable_next;
  logic                pwrite_reg, pwrite_next;
  logic [ADDR_W-1:0]   paddr_reg, paddr_next;
  logic [DATA_W-1:0]   pwdata_reg, pwdata_next;
  logic                any_valid;
  logic [SUM_W-1:0]    idx_sum;
  logic [ADDR_W-1:0]   addr_arr  [NREQ];
  logic [DATA_W-1:0]   wdata_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
    assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
  end

  // Scan the offsets from the highest to the lowest, so the requester nearest to ptr is the one left in pick.
  always_comb begin
    pick      = '0;
    idx_sum   = '0;
    any_valid = |req_valid;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx_sum = {1'b0, ptr_reg} + SUM_W'(k);
      if (idx_sum >= SUM_W'(NREQ)) idx_sum = idx_sum - SUM_W'(NREQ);
      if (req_valid[idx_sum[ID_W-1:0]]) pick = idx_sum[ID_W-1:0];
    end
  end

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    gnt_next       = gnt_reg;
    cnt_next       = cnt_reg;
    ready_next     = '0;
    rsp_valid_next = 1'b0;
    rsp_id_next    = rsp_id_reg;
    rsp_rdata_next = rsp_rdata_reg;
    rsp_err_next   = rsp_err_reg;
    rsp_tmo_next   = rsp_tmo_reg;
    psel_next      = psel_reg;
    penable_next   = penable_reg;
    pwrite_next    = pwrite_reg;
    paddr_next     = paddr_reg;
    pwdata_next    = pwdata_reg;
    case (state_reg)
      IDLE: begin
        if (any_valid) begin
          state_next       = SETUP;
          gnt_next         = pick;
          ptr_next         = (pick == ID_W'(NREQ - 1)) ? '0 : pick + 1'b1;
          ready_next[pick] = 1'b1;
          psel_next        = 1'b1;
          penable_next     = 1'b0;
          pwrite_next      = req_write[pick];
          paddr_next       = addr_arr[pick];
          pwdata_next      = wdata_arr[pick];
        end
      end
      SETUP: begin
        state_next   = ACCESS;
        penable_next = 1'b1;
      end
      ACCESS: begin
        // If PREADY arrives on the same edge that would reach the limit, the normal completion takes priority.
        if (PREADY) begin
          state_next     = IDLE;
          cnt_next       = '0;
          psel_next      = 1'b0;
          penable_next   = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_id_next    = gnt_reg;
          rsp_err_next   = PSLVERR;
          rsp_tmo_next   = 1'b0;
          rsp_rdata_next = pwrite_reg ? '0 : PRDATA;
        end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
          state_next     = IDLE;
          cnt_next       = '0;
          psel_next      = 1'b0;
          penable_next   = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_id_next    = gnt_reg;
          rsp_err_next   = 1'b1;
          rsp_tmo_next   = 1'b1;
          rsp_rdata_next = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      gnt_reg       <= '0;
      cnt_reg       <= '0;
      ready_reg     <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= '0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
      rsp_tmo_reg   <= 1'b0;
      psel_reg      <= 1'b0;
      penable_reg   <= 1'b0;
      pwrite_reg    <= 1'b0;
      paddr_reg     <= '0;
      pwdata_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      gnt_reg       <= gnt_next;
      cnt_reg       <= cnt_next;
      ready_reg     <= ready_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_id_reg    <= rsp_id_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_err_reg   <= rsp_err_next;
      rsp_tmo_reg   <= rsp_tmo_next;
      psel_reg      <= psel_next;
      penable_reg   <= penable_next;
      pwrite_reg    <= pwrite_next;
      paddr_reg     <= paddr_next;
      pwdata_reg    <= pwdata_next;
    end
  end

  assign req_ready = ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_id    = rsp_id_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;
  assign rsp_tmo   = rsp_tmo_reg;
  assign PSEL      = psel_reg;
  assign PENABLE   = penable_reg;
  assign PWRITE    = pwrite_reg;
  assign PADDR     = paddr_reg;
  assign PWDATA    = pwdata_reg;
endmodule
